// File: rtl/service_map_ctrl.sv
// Quiesce-and-swap controller for the service crossbar L2 prog/data address map.
// Throttles AW/AR at a global outstanding cap, drains all traffic on a map update, then swaps atomically.
module service_map_ctrl #(
    parameter int unsigned          NumClusters    = 4,
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          MaxOutstanding = 16,
    parameter int unsigned          DrainTimeout   = 1024,
    parameter logic [AddrWidth-1:0] RstL2iStart    = '0,
    parameter logic [AddrWidth-1:0] RstL2iEnd      = '0,
    parameter logic [AddrWidth-1:0] RstL2dStart    = '0,
    parameter logic [AddrWidth-1:0] RstL2dEnd      = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [AddrWidth-1:0]   cfg_l2i_start_i,
    input  logic [AddrWidth-1:0]   cfg_l2i_end_i,
    input  logic [AddrWidth-1:0]   cfg_l2d_start_i,
    input  logic [AddrWidth-1:0]   cfg_l2d_end_i,
    output logic [AddrWidth-1:0]   l2i_start_addr_o,
    output logic [AddrWidth-1:0]   l2i_end_addr_o,
    output logic [AddrWidth-1:0]   l2d_start_addr_o,
    output logic [AddrWidth-1:0]   l2d_end_addr_o,
    input  logic [NumClusters-1:0] aw_valid_i,
    output logic [NumClusters-1:0] aw_valid_o,
    input  logic [NumClusters-1:0] aw_ready_i,
    output logic [NumClusters-1:0] aw_ready_o,
    input  logic [NumClusters-1:0] ar_valid_i,
    output logic [NumClusters-1:0] ar_valid_o,
    input  logic [NumClusters-1:0] ar_ready_i,
    output logic [NumClusters-1:0] ar_ready_o,
    input  logic [NumClusters-1:0] b_valid_i,
    input  logic [NumClusters-1:0] b_ready_i,
    input  logic [NumClusters-1:0] r_valid_i,
    input  logic [NumClusters-1:0] r_ready_i,
    input  logic [NumClusters-1:0] r_last_i,
    output logic                   busy_o,
    output logic                   timeout_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned DrnW = $clog2(DrainTimeout + 1);
    localparam logic [CntW-1:0] OpenLimit  = CntW'(MaxOutstanding - NumClusters);
    localparam logic [DrnW-1:0] DrainLimit = DrnW'(DrainTimeout);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [NumClusters-1:0] aw_pend_q, aw_pend_d, ar_pend_q, ar_pend_d;
    logic [DrnW-1:0]        drain_cnt_q, drain_cnt_d;
    logic                   timeout_q, timeout_d, cfg_ready_q, cfg_ready_d, busy_q, busy_d;
    logic [AddrWidth-1:0]   l2i_start_q, l2i_start_d, l2i_end_q, l2i_end_d;
    logic [AddrWidth-1:0]   l2d_start_q, l2d_start_d, l2d_end_q, l2d_end_d;
    logic                   open_w, open_r, wr_underflow, rd_underflow;
    logic [NumClusters-1:0] aw_hs, ar_hs, b_hs, r_hs;
    logic signed [31:0]     wr_sum, rd_sum;

    function automatic logic signed [31:0] popcnt(input logic [NumClusters-1:0] v);
        logic signed [31:0] n;
        n = '0;
        for (int unsigned i = 0; i < NumClusters; i++) begin
            if (v[i]) n = n + 32'sd1;
        end
        return n;
    endfunction

    always_comb begin
        open_w = (state_q == IDLE) && (wr_cnt_q <= OpenLimit);
        open_r = (state_q == IDLE) && (rd_cnt_q <= OpenLimit);
        // A valid already shown to the xbar bypasses the gate until it handshakes.
        aw_valid_o = aw_valid_i & ({NumClusters{open_w}} | aw_pend_q);
        aw_ready_o = aw_ready_i & ({NumClusters{open_w}} | aw_pend_q);
        ar_valid_o = ar_valid_i & ({NumClusters{open_r}} | ar_pend_q);
        ar_ready_o = ar_ready_i & ({NumClusters{open_r}} | ar_pend_q);
        aw_hs = aw_valid_o & aw_ready_i;
        ar_hs = ar_valid_o & ar_ready_i;
        b_hs  = b_valid_i & b_ready_i;
        r_hs  = r_valid_i & r_ready_i & r_last_i;
        aw_pend_d = aw_valid_o & ~aw_ready_i;
        ar_pend_d = ar_valid_o & ~ar_ready_i;

        wr_sum = int'(wr_cnt_q) + popcnt(aw_hs) - popcnt(b_hs);
        rd_sum = int'(rd_cnt_q) + popcnt(ar_hs) - popcnt(r_hs);
        wr_underflow = (wr_sum < 0);
        rd_underflow = (rd_sum < 0);
        wr_cnt_d = wr_underflow ? '0 : CntW'(wr_sum);
        rd_cnt_d = rd_underflow ? '0 : CntW'(rd_sum);

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
        l2i_start_d = l2i_start_q;
        l2i_end_d   = l2i_end_q;
        l2d_start_d = l2d_start_q;
        l2d_end_d   = l2d_end_q;
        unique case (state_q)
            IDLE: begin
                drain_cnt_d = '0;
                if (cfg_valid_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q != DrainLimit) drain_cnt_d = drain_cnt_q + DrnW'(1);
                if (drain_cnt_d == DrainLimit) timeout_d = 1'b1;
                if (wr_cnt_q == '0 && rd_cnt_q == '0 && aw_pend_q == '0 && ar_pend_q == '0)
                    state_d = SWAP;
            end
            SWAP: begin
                l2i_start_d = cfg_l2i_start_i;
                l2i_end_d   = cfg_l2i_end_i;
                l2d_start_d = cfg_l2d_start_i;
                l2d_end_d   = cfg_l2d_end_i;
                timeout_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d == SWAP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            aw_pend_q   <= '0;
            ar_pend_q   <= '0;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            l2i_start_q <= RstL2iStart;
            l2i_end_q   <= RstL2iEnd;
            l2d_start_q <= RstL2dStart;
            l2d_end_q   <= RstL2dEnd;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            aw_pend_q   <= aw_pend_d;
            ar_pend_q   <= ar_pend_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            l2i_start_q <= l2i_start_d;
            l2i_end_q   <= l2i_end_d;
            l2d_start_q <= l2d_start_d;
            l2d_end_q   <= l2d_end_d;
        end
    end

    assign cfg_ready_o      = cfg_ready_q;
    assign busy_o           = busy_q;
    assign timeout_o        = timeout_q;
    assign l2i_start_addr_o = l2i_start_q;
    assign l2i_end_addr_o   = l2i_end_q;
    assign l2d_start_addr_o = l2d_start_q;
    assign l2d_end_addr_o   = l2d_end_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!wr_underflow && !rd_underflow)
                else $error("service_map_ctrl: outstanding counter decremented below zero");
            assert (!(state_q == DRAIN && !cfg_valid_i))
                else $error("service_map_ctrl: cfg_valid_i dropped while draining");
        end
    end
`endif
endmodule
